// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package imem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} load_state_e;

  localparam int IMEM_DATA_WIDTH = 32;
  localparam int IMEM_DEPTH      = 1024;
endpackage

// File: rtl/imem_bram_1clk.sv
// Single-clock simple dual-port RAM: one write port, one registered read-first read port.
module imem_bram_1clk #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read and write in one block so a same-address collision returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
    if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;
endmodule

// File: rtl/imem_loader_bram.sv
// Instruction memory with handshaked burst loader, running checksum and registered read port.
module imem_loader_bram
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] load_base_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic                  load_abort_i,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic [DATA_WIDTH-1:0] load_sum_o,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W     = (ADDR_WIDTH + 1)'(1);

  load_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_rd_valid;
  logic                  r_rd_oob;

  logic                  w_load;
  logic                  w_accept;
  logic                  w_rd_inrange;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_load       = (r_state == LOAD);
  assign w_accept     = w_load && load_valid_i && !load_abort_i;
  assign w_rd_inrange = ({1'b0, rd_addr_i} < DEPTH_W);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: if (load_start_i) begin
          r_ptr   <= load_base_i;
          r_cnt   <= load_len_i;
          r_sum   <= '0;
          r_state <= (load_len_i == '0) ? DONE : LOAD;
        end
        LOAD: if (load_abort_i) begin
          r_state <= IDLE;
        end else if (load_valid_i) begin
          r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
          r_cnt <= r_cnt - ONE_W;
          r_sum <= r_sum + load_data_i;
          if (r_cnt == ONE_W) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Out-of-range flag resets high so rd_data_o reads 0 without resetting the RAM output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b1;
    end else begin
      r_rd_valid <= rd_en_i;
      if (rd_en_i) r_rd_oob <= !w_rd_inrange;
    end
  end

  imem_bram_1clk #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_accept),
    .waddr_i (r_ptr),
    .wdata_i (load_data_i),
    .re_i    (rd_en_i && w_rd_inrange),
    .raddr_i (rd_addr_i),
    .rdata_o (w_ram_q)
  );

  assign load_ready_o = w_load;
  assign load_busy_o  = w_load;
  assign load_done_o  = (r_state == DONE);
  assign load_sum_o   = r_sum;
  assign rd_data_o    = r_rd_oob ? '0 : w_ram_q;
  assign rd_valid_o   = r_rd_valid;
endmodule

// File: tb/tb_imem_loader_bram.sv
// Scoreboard bench for imem_loader_bram (non power-of-two depth to reach out-of-range reads).
module tb_imem_loader_bram;
  localparam int DW  = 32;
  localparam int DEP = 12;
  localparam int AW  = $clog2(DEP);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          load_start_i = 1'b0;
  logic [AW-1:0] load_base_i = '0;
  logic [AW:0]   load_len_i = '0;
  logic          load_abort_i = 1'b0;
  logic          load_valid_i = 1'b0;
  logic [DW-1:0] load_data_i = '0;
  logic          load_ready_o, load_busy_o, load_done_o;
  logic [DW-1:0] load_sum_o;
  logic          rd_en_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;

  imem_loader_bram #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .load_start_i(load_start_i), .load_base_i(load_base_i), .load_len_i(load_len_i),
    .load_abort_i(load_abort_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_ready_o(load_ready_o), .load_busy_o(load_busy_o), .load_done_o(load_done_o),
    .load_sum_o(load_sum_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int            total = 0;
  int            bad = 0;
  int            done_seen = 0;
  logic [DW-1:0] mdl [16];
  logic [DW-1:0] rq [$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; compare any read issued for this edge against the scoreboard.
  task automatic step();
    logic pend;
    pend = rd_en_i;
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    done_seen += int'(load_done_o);
    if (pend) begin
      chk("rd_valid", {31'd0, rd_valid_o}, 1);
      if (rq.size() == 0) chk("rq_underflow", 1, 0);
      else chk("rd_data", rd_data_o, rq.pop_front());
    end else begin
      chk("rd_valid_idle", {31'd0, rd_valid_o}, 0);
    end
  endtask

  task automatic rd(input int a);
    rd_en_i   = 1'b1;
    rd_addr_i = AW'(a);
    rq.push_back((a >= DEP) ? '0 : mdl[a]);
  endtask

  task automatic start(input int base, input int len);
    load_start_i = 1'b1;
    load_base_i  = AW'(base);
    load_len_i   = (AW + 1)'(len);
    step();
    load_start_i = 1'b0;
  endtask

  task automatic beat(input int a, input logic [DW-1:0] d);
    load_valid_i = 1'b1;
    load_data_i  = d;
    chk("beat_ready", {31'd0, load_ready_o}, 1);
    step();
    mdl[a] = d;
    load_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [DW-1:0] wd [4];
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'd0, load_ready_o}, 0);
    chk("rst_busy",  {31'd0, load_busy_o}, 0);
    chk("rst_done",  {31'd0, load_done_o}, 0);
    chk("rst_sum",   load_sum_o, 0);
    chk("rst_rdata", rd_data_o, 0);
    chk("rst_rvld",  {31'd0, rd_valid_o}, 0);
    #3 rst_ni = 1'b1;
    step();

    // Basic burst, valid held high for all 4 beats
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    start(0, 4);
    chk("b1_ready_after_start", {31'd0, load_ready_o}, 1);
    chk("b1_busy", {31'd0, load_busy_o}, 1);
    load_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_data_i = wd[i];
      chk("b1_ready", {31'd0, load_ready_o}, 1);
      chk("b1_done_early", {31'd0, load_done_o}, 0);
      step();
      mdl[i] = wd[i];
    end
    load_valid_i = 1'b0;
    chk("b1_done", {31'd0, load_done_o}, 1);
    chk("b1_ready_off", {31'd0, load_ready_o}, 0);
    chk("b1_sum", load_sum_o, 32'hAA);
    step();
    chk("b1_done_1cyc", {31'd0, load_done_o}, 0);
    for (int a = 0; a < 4; a++) begin rd(a); step(); end

    // Wrapping burst 10,11,0,1 -> overwrite 0,1; 2 untouched
    d0 = done_seen;
    start(10, 4);
    beat(10, 32'hA); beat(11, 32'hB); beat(0, 32'hC); beat(1, 32'hD);
    chk("wr_sum", load_sum_o, 32'h2E);
    repeat (3) step();
    chk("wr_done_cnt", DW'(done_seen - d0), 1);
    rd(10); step(); rd(11); step(); rd(0); step(); rd(1); step(); rd(2); step();

    // Zero-length burst
    start(5, 0);
    chk("z_ready", {31'd0, load_ready_o}, 0);
    chk("z_busy", {31'd0, load_busy_o}, 0);
    chk("z_done", {31'd0, load_done_o}, 1);
    chk("z_sum", load_sum_o, 0);
    step();
    chk("z_done_off", {31'd0, load_done_o}, 0);

    // Abort after 2 of 5 beats, with a valid beat in the abort cycle
    d0 = done_seen;
    start(1, 5);
    beat(1, 32'h100); beat(2, 32'h200);
    load_valid_i = 1'b1; load_data_i = 32'hDEAD; load_abort_i = 1'b1;
    step();
    load_valid_i = 1'b0; load_abort_i = 1'b0;
    chk("ab_busy", {31'd0, load_busy_o}, 0);
    chk("ab_sum", load_sum_o, 32'h300);
    repeat (2) step();
    chk("ab_no_done", DW'(done_seen - d0), 0);
    rd(1); step(); rd(2); step(); rd(3); step();

    // Following start accepted; then read-first collision
    start(7, 1);
    chk("ab_restart_busy", {31'd0, load_busy_o}, 1);
    beat(7, 32'h1234);
    step();
    start(7, 1);
    rd(7);
    beat(7, 32'hBEEF);
    rd(7); step();

    // Out-of-range reads
    rd(12); step(); rd(15); step();

    // Async reset mid-burst
    rd(0); step();
    start(9, 3);
    beat(9, 32'h5555);
    load_valid_i = 1'b1; load_data_i = 32'h6666;
    rst_ni = 1'b0;
    #1;
    chk("mr_busy", {31'd0, load_busy_o}, 0);
    chk("mr_ready", {31'd0, load_ready_o}, 0);
    chk("mr_done", {31'd0, load_done_o}, 0);
    chk("mr_sum", load_sum_o, 0);
    chk("mr_rdata", rd_data_o, 0);
    chk("mr_rvld", {31'd0, rd_valid_o}, 0);
    load_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step();
    chk("mr_idle_busy", {31'd0, load_busy_o}, 0);
    rd(0); step(); rd(9); step(); rd(7); step(); rd(13); step();
    step();
    chk("rq_empty", DW'(rq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader_bram.md
# imem_loader_bram

Single-clock, parametrised instruction-memory block: block-RAM storage with a handshaked, auto-incrementing burst load port and a registered processor read port. It runs in the processor clock domain and is fed by the TAP data path after that path has been synchronised. A small state machine sequences each load burst and reports busy, done and a running additive checksum, so the debug host can verify the image before releasing the core.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 1024, number of words. Any value ≥ 2; power of two not required.
- ADDR_WIDTH, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk_i  in  1  processor clock. All logic is on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- load_start_i  in  1  starts a burst. Honoured only in IDLE.
- load_base_i  in  ADDR_WIDTH  first word address of the burst. Sampled with start.
- load_len_i  in  ADDR_WIDTH+1  word count, 0..DEPTH. Sampled with start.
- load_abort_i  in  1  terminates a burst in LOAD.
- load_valid_i  in  1  load word valid.
- load_data_i  in  DATA_WIDTH  load word.
- load_ready_o  out  1  block accepts a word; high only in LOAD.
- load_busy_o  out  1  high in LOAD.
- load_done_o  out  1  one-cycle pulse when a burst completes normally.
- load_sum_o  out  DATA_WIDTH  running sum of accepted words, mod 2^DATA_WIDTH.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  read word address.
- rd_data_o  out  DATA_WIDTH  read data.
- rd_valid_o  out  1  rd_data_o holds the result of the previous-cycle request.

## Operation
- States (load_state_e): IDLE, LOAD, DONE.
- IDLE:
  - On load_start_i, capture base into the address pointer and len into the remaining-word counter, and clear load_sum_o.
  - If len = 0, go to DONE; otherwise go to LOAD.
- LOAD:
  - A beat is accepted when load_valid_i && load_ready_o.
  - Each accepted beat writes mem[ptr] = load_data_i, adds the word to load_sum_o, increments ptr and decrements the counter.
  - ptr wraps from DEPTH-1 to 0.
  - Accepting the last word moves the FSM to DONE.
- load_abort_i in LOAD:
  - Return to IDLE with no done pulse.
  - Words already written and the sum so far are retained.
  - Abort has priority over a beat in the same cycle; that beat is not written.
- DONE: load_done_o = 1 for exactly one cycle, then IDLE.
- load_start_i outside IDLE is ignored. load_abort_i outside LOAD is ignored.
- Read port:
  - On rd_en_i, rd_data_o <= mem[rd_addr_i] and rd_valid_o <= 1.
  - Without rd_en_i, rd_data_o holds its value and rd_valid_o <= 0.
  - rd_addr_i ≥ DEPTH returns 0 with rd_valid_o = 1.
  - Reads are allowed in every state; the core is expected to be held in reset while load_busy_o is high.
- Collision (read and write to the same address in one cycle) is read-first: rd_data_o returns the old word.
- Memory contents are not reset.

## Timing
- Reset values: load_ready_o = 0, load_busy_o = 0, load_done_o = 0, load_sum_o = 0, rd_data_o = 0, rd_valid_o = 0. State is IDLE; pointer and counter are 0.
- Start to ready: load_ready_o rises in the cycle after load_start_i is sampled.
- Load throughput: one word per cycle sustained.
- Write timing: a word accepted on edge N is readable by a request presented in cycle N+1; data appears on edge N+2.
- Done latency: load_done_o is high in the cycle after the last beat is accepted. With len = 0 it is high in the cycle after start.
- load_sum_o updates on the same edge as the write.
- Read latency: 1 cycle.
- Reset asserted mid-burst: FSM returns to IDLE immediately (asynchronously) with no done pulse. Words written before reset persist.

## Structure
- Shared package imem_pkg holds:
  - typedef enum logic [1:0] load_state_e {IDLE, LOAD, DONE};
  - default constants IMEM_DATA_WIDTH and IMEM_DEPTH.
- Sub-module imem_bram_1clk: a single-clock simple dual-port RAM (one write port, one registered read-first read port) carrying the block-RAM inference attribute.
- The top level contains the FSM, pointer, counter, checksum and out-of-range read masking.

## Test plan
- Reset, then burst base=0, len=4, data 0x11,0x22,0x33,0x44 with valid held high -> ready for 4 cycles; done pulses one cycle after the 4th beat; sum = 0xAA; reads of addresses 0..3 return those words, each one cycle after rd_en.
- DEPTH=8, base=6, len=4, data A,B,C,D -> words land at addresses 6,7,0,1; done pulses once.
- len=0 start -> no ready cycle; done high in the cycle after start; sum = 0.
- Abort after 2 of 5 beats, with a valid beat in the abort cycle -> no done pulse; exactly 2 words written; sum equals those 2 words; the following start is accepted.
- Same-cycle write of 0xBEEF and read of the same address holding 0x1234 -> rd_data = 0x1234; a read the next cycle returns 0xBEEF.
- rst_ni pulsed low mid-burst -> busy and ready drop immediately; all outputs take reset values; earlier-written words remain readable; rd_addr ≥ DEPTH returns 0.
